// File: rtl/int_to_float_pkg.sv
// Shared single-precision float definitions: field widths, exponent bias and
// the conversion state encoding, common to the int-to-float and adder stages.
package int_to_float_pkg;

  localparam int unsigned SIGN_W         = 1;
  localparam int unsigned EXP_W          = 8;
  localparam int unsigned MAN_W          = 23;
  localparam int unsigned FLOAT_W        = SIGN_W + EXP_W + MAN_W;
  localparam int unsigned FLOAT_EXP_BIAS = 127;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    NORM,
    ROUND,
    OUT
  } conv_state_e;

endpackage

// File: rtl/int_to_float_round_nearest_even.sv
// Round a normalised magnitude (hidden bit dropped) to a 23-bit mantissa using
// round-to-nearest, ties-to-even; a carry out of the mantissa bumps the exponent.
module round_nearest_even
  import int_to_float_pkg::*;
(
  input  logic [30:0]      mag_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic [MAN_W-1:0] man_o,
  output logic [EXP_W-1:0] exp_o
);

  logic             guardBit;
  logic             stickyBit;
  logic             roundUp;
  logic [MAN_W:0]   manSum;
  logic             manCarry;

  assign guardBit  = mag_i[7];
  assign stickyBit = |mag_i[6:0];
  // The mantissa LSB breaks exact ties toward an even result.
  assign roundUp   = guardBit & (stickyBit | mag_i[8]);
  assign manSum    = {1'b0, mag_i[30:8]} + {{MAN_W{1'b0}}, roundUp};
  assign manCarry  = manSum[MAN_W];

  assign man_o = manCarry ? '0 : manSum[MAN_W-1:0];
  assign exp_o = exp_i + {{(EXP_W-1){1'b0}}, manCarry};

endmodule

// File: rtl/int_to_float.sv
// Multi-cycle signed 32-bit integer to IEEE-754 single converter with a
// valid/ready handshake on each side; normalises one bit position per cycle.
module int_to_float
  import int_to_float_pkg::*;
#(
  parameter int unsigned EXP_BIAS = FLOAT_EXP_BIAS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [FLOAT_W-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [FLOAT_W-1:0] out_data,
  input  logic               out_ready
);

  // A full 32-bit magnitude has its MSB at weight 2^31.
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + 31);

  conv_state_e         state_q, state_d;
  logic [SIGN_W-1:0]   sign_q, sign_d;
  logic [31:0]         mag_q, mag_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [FLOAT_W-1:0]  out_q, out_d;

  logic [31:0]         absMag;
  logic [MAN_W-1:0]    rndMan;
  logic [EXP_W-1:0]    rndExp;

  assign absMag = sign_q[0] ? (~mag_q + 32'd1) : mag_q;

  round_nearest_even u_round (
    .mag_i (mag_q[30:0]),
    .exp_i (exp_q),
    .man_o (rndMan),
    .exp_o (rndExp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= '0;
      mag_q   <= '0;
      exp_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[FLOAT_W-1 -: SIGN_W];
          mag_d   = in_data;
          state_d = ABS;
        end
      end
      ABS: begin
        mag_d = absMag;
        exp_d = EXP_TOP;
        if (absMag == 32'd0) begin
          out_d   = '0;
          state_d = OUT;
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = ROUND;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - EXP_W'(1);
        end
      end
      ROUND: begin
        out_d   = {sign_q, rndExp, rndMan};
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_q;

endmodule

// File: tb/tb_int_to_float.sv
// Scoreboard bench for int_to_float: directed vectors with hand-computed
// results, handshake corner cases, and a model-checked signed sweep.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  int          compCount = 0;
  int          failCount = 0;
  logic [31:0] expQ[$];

  int_to_float #(.EXP_BIAS(127)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Independent reference: locate the MSB, then round the discarded bits
  // with integer arithmetic.
  function automatic logic [31:0] refConvert(input logic [31:0] v);
    longint a, q, rem, half;
    int     p, sh;
    logic   s;
    s = v[31];
    a = s ? -longint'($signed(v)) : longint'(v);
    if (a == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 32; i++) if (a[i]) p = i;
    if (p <= 23) begin
      q = a << (23 - p);
    end else begin
      sh   = p - 23;
      q    = a >> sh;
      rem  = a & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'sd1 << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    return {s, 8'(127 + p), q[22:0]};
  endfunction

  // Monitor: every completed output handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        compCount++;
        failCount++;
        $display("[TB] FAIL unexpectedOutput: got %h, expected no output", out_data);
      end else begin
        checkOutput("result", out_data, expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] v, input logic [31:0] exp, input bit expectOut);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("inReadyTimeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    if (expectOut) expQ.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int waited = 0;
    while (expQ.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
  endtask

  initial begin
    logic [31:0] heldData;
    logic [31:0] rv;
    int          waited;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("resetOutValid", {31'd0, out_valid}, 32'd0);
    checkOutput("resetOutData", out_data, 32'h0);
    checkOutput("resetInReady", {31'd0, in_ready}, 32'd1);

    applyStimulus(32'd1, 32'h3F800000, 1'b1);           waitDrain();
    applyStimulus(32'hFFFFFFFF, 32'hBF800000, 1'b1);    waitDrain();
    applyStimulus(32'h7FFFFFFF, 32'h4F000000, 1'b1);    waitDrain();
    applyStimulus(32'h80000000, 32'hCF000000, 1'b1);    waitDrain();
    applyStimulus(32'd16777217, 32'h4B800000, 1'b1);    waitDrain();
    applyStimulus(32'd16777219, 32'h4B800002, 1'b1);    waitDrain();
    applyStimulus(32'd16777216, 32'h4B800000, 1'b1);    waitDrain();
    applyStimulus(32'd3, 32'h40400000, 1'b1);           waitDrain();
    applyStimulus(-32'sd100, 32'hC2C80000, 1'b1);       waitDrain();

    // Zero bypasses normalisation and is presented two cycles after accept.
    out_ready = 1'b0;
    applyStimulus(32'd0, 32'h00000000, 1'b1);
    checkOutput("zeroNotEarly", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    checkOutput("zeroLatency", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    waitDrain();

    // Backpressure: result must hold while new operands are offered.
    out_ready = 1'b0;
    applyStimulus(32'd1, 32'h3F800000, 1'b1);
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("bpValidSeen", {31'd0, out_valid}, 32'd1);
    heldData = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'd12345;
      @(negedge clk);
      checkOutput("bpOutValid", {31'd0, out_valid}, 32'd1);
      checkOutput("bpOutData", out_data, heldData);
      checkOutput("bpInReady", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitDrain();
    repeat (40) @(negedge clk);

    // Reset in the middle of normalising 1 (31 shift cycles).
    applyStimulus(32'd1, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstOutValid", {31'd0, out_valid}, 32'd0);
    checkOutput("midRstInReady", {31'd0, in_ready}, 32'd1);
    checkOutput("midRstOutData", out_data, 32'h0);
    repeat (40) @(negedge clk);
    applyStimulus(32'd2, 32'h40000000, 1'b1);           waitDrain();

    // Signed sweep across all leading-zero counts against the model.
    for (int n = 0; n < 1500; n++) begin
      rv = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rv = -rv;
      applyStimulus(rv, refConvert(rv), 1'b1);
      waitDrain();
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", compCount, failCount);
    $finish;
  end

endmodule
